// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared state encoding, pixel layout and timing defaults
package neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_BIT_HIGH = 3'd2,
        ST_BIT_LOW  = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    // Pixel word is {G,R,B}, sent MSB first so G7 leads the wire.
    localparam int PIX_W = 24;
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // Cycle counts for a 50 MHz system clock.
    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_RESET_CYC = 3000;

    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/neopixel_fbuf.sv
// rtl/neopixel_fbuf.sv - pixel frame buffer, one write port and one registered read port
module neopixel_fbuf
    import neopixel_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    // No reset on purpose: the array must map onto RAM primitives.
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/neopixel_strip_ctrl.sv
// rtl/neopixel_strip_ctrl.sv - WS2812-class strip controller: frame buffer, bit timing FSM, pin driver
module neopixel_strip_ctrl
    import neopixel_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_W       = 8,
    parameter int T0H_CYC      = DEF_T0H_CYC,
    parameter int T1H_CYC      = DEF_T1H_CYC,
    parameter int BIT_CYC      = DEF_BIT_CYC,
    parameter int RESET_CYC    = DEF_RESET_CYC,
    parameter int AUTO_REFRESH = 0,
    parameter int INVERT_OUT   = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [23:0]       i_wr_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_led_out
);

    localparam int IDX_W = cnt_width(NUM_LEDS);
    localparam int CNT_W = cnt_width((BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC);
    localparam int BIT_W = cnt_width(PIX_W);

    localparam logic [CNT_W-1:0]  T0H_LAST     = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0]  T1H_LAST     = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RESET_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_PIX     = IDX_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_LEDS_EXT = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [BIT_W-1:0]  FIRST_BIT    = BIT_W'(PIX_W - 1);
    localparam logic              INV_BIT      = (INVERT_OUT != 0);
    localparam logic              AUTO_BIT     = (AUTO_REFRESH != 0);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   pix;
    logic [PIX_W-1:0]   sr;
    logic               pending;
    logic               led_q;

    logic               wr_ok;
    logic [IDX_W-1:0]   fetch_addr;
    logic [PIX_W-1:0]   rd_data;
    logic [CNT_W-1:0]   high_last;
    logic               last_pix;
    logic               cnt_run;
    logic               load_first;
    logic               bit_adv;
    logic               frame_done;

    assign wr_ok = i_wr_en && ({1'b0, i_wr_addr} < NUM_LEDS_EXT);

    neopixel_fbuf #(
        .DEPTH (NUM_LEDS),
        .IDX_W (IDX_W)
    ) u_fbuf (
        .i_clk   (i_clk),
        .wr_en   (wr_ok),
        .wr_addr (i_wr_addr[IDX_W-1:0]),
        .wr_data (i_wr_data),
        .rd_addr (fetch_addr),
        .rd_data (rd_data)
    );

    assign high_last = sr[G_MSB] ? T1H_LAST : T0H_LAST;
    assign last_pix  = (pix == LAST_PIX);

    // The read port streams the next pixel continuously, so the word caught at
    // the pixel boundary reflects writes up to the last couple of cycles.
    assign fetch_addr = ((state == ST_BIT_HIGH || state == ST_BIT_LOW) && !last_pix)
                        ? pix + IDX_W'(1) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_run    = 1'b0;
        load_first = 1'b0;
        bit_adv    = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_first = 1'b1;
                state_next = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                cnt_run = 1'b1;
                if (cnt == high_last) begin
                    state_next = ST_BIT_LOW;
                end
            end
            ST_BIT_LOW: begin
                if (cnt != BIT_LAST) begin
                    cnt_run = 1'b1;
                end else if (bit_idx == '0 && last_pix) begin
                    state_next = ST_LATCH;
                end else begin
                    bit_adv    = 1'b1;
                    state_next = ST_BIT_HIGH;
                end
            end
            ST_LATCH: begin
                if (cnt != RST_LAST) begin
                    cnt_run = 1'b1;
                end else begin
                    frame_done = 1'b1;
                    state_next = (pending || i_start || AUTO_BIT) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            pix     <= '0;
            sr      <= '0;
            pending <= 1'b0;
            led_q   <= INV_BIT;
        end else begin
            cnt   <= cnt_run ? cnt + CNT_W'(1) : '0;
            // Driven from the next state so the pin lines up with the FSM phase.
            led_q <= (state_next == ST_BIT_HIGH) ^ INV_BIT;

            if (frame_done) begin
                pending <= 1'b0;
            end else if (i_start && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            if (load_first) begin
                sr      <= rd_data;
                bit_idx <= FIRST_BIT;
                pix     <= '0;
            end else if (bit_adv) begin
                if (bit_idx == '0) begin
                    sr      <= rd_data;
                    bit_idx <= FIRST_BIT;
                    pix     <= pix + IDX_W'(1);
                end else begin
                    sr      <= {sr[PIX_W-2:0], 1'b0};
                    bit_idx <= bit_idx - BIT_W'(1);
                end
            end
        end
    end

    assign o_busy       = (state != ST_IDLE);
    assign o_frame_done = frame_done;
    assign o_led_out    = led_q;

endmodule

// File: doc/neopixel_strip_ctrl.md
Name: neopixel_strip_ctrl

Overview:
Parametrised WS2812-class LED strip controller with an internal frame buffer and a host write port. It generates the one-wire NRZ waveform directly from the system clock using cycle-count timing, with no divided clock. It supports any LED count, a configurable output polarity, single-shot or auto-refresh modes, and start requests queued while a frame is in flight. It sits between the CPU bus (pixel writes) and the board LED pin.

Parameters:
NUM_LEDS, 8, pixels in the chain (1..256)
ADDR_W, 8, width of the pixel address; must hold NUM_LEDS-1
T0H_CYC, 20, high cycles for a 0 bit (400 ns at 50 MHz)
T1H_CYC, 40, high cycles for a 1 bit (800 ns at 50 MHz)
BIT_CYC, 63, total cycles per bit; requires T0H_CYC < T1H_CYC < BIT_CYC
RESET_CYC, 3000, low cycles of the latch gap after a frame (60 us)
AUTO_REFRESH, 0, 1 = start a new frame automatically after every latch gap
INVERT_OUT, 0, 1 = o_led_out is the logical inverse of the waveform (inverting level shifter)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_wr_en  in  1  pixel write strobe
i_wr_addr  in  ADDR_W  pixel index
i_wr_data  in  24  pixel colour {G[7:0],R[7:0],B[7:0]}
i_start  in  1  request one frame transmission (level sampled each cycle)
o_busy  out  1  high from start acceptance until the end of the latch gap
o_frame_done  out  1  one-cycle pulse at the end of the latch gap
o_led_out  out  1  serial data to the LED chain

Behaviour:
- Reset: FSM to IDLE; o_busy=0, o_frame_done=0, o_led_out=INVERT_OUT (waveform low); pending flag cleared; all counters zeroed. The frame buffer is RAM and is not cleared by reset.
- Reset mid-frame: the waveform is low on the cycle after i_reset is sampled high. The frame is aborted with no o_frame_done pulse.
- Writes: when i_wr_en=1 and i_wr_addr<NUM_LEDS, the buffer entry is written at the clock edge. Writes with i_wr_addr>=NUM_LEDS are ignored. Writes are accepted in every state.
- Write/transmit interaction: a pixel is snapshotted into the shift register when its first bit starts. A write to a pixel already loaded or sent takes effect in the next frame. A write to a later pixel takes effect in the current frame.
- FSM states: IDLE -> LOAD -> BIT_HIGH -> BIT_LOW -> (BIT_HIGH | LATCH) -> IDLE or LOAD.
  - IDLE: if i_start=1 at edge k, then LOAD at k+1 with o_busy=1.
  - LOAD: reads pixel 0 (one-cycle synchronous read).
  - BIT_HIGH: entered at k+2; the waveform goes high from k+2.
  - Bit timing: each bit is exactly BIT_CYC cycles. The high phase lasts T1H_CYC for a 1 and T0H_CYC for a 0; the remainder is low.
- Bit order: pixel 0 first, MSB first within the 24-bit word (G7 first, B0 last).
- No gaps: the next pixel is prefetched during the current pixel, so bit periods are contiguous across pixel boundaries. The total frame is NUM_LEDS*24*BIT_CYC cycles.
- LATCH: after the last bit's low phase, the waveform is held low for RESET_CYC cycles. On the final LATCH cycle, o_frame_done=1 for one cycle. Then:
  - If the pending flag is set or AUTO_REFRESH=1: go to LOAD, clear the pending flag, keep o_busy=1.
  - Otherwise: go to IDLE, with o_busy=0 on the next cycle.
- i_start while o_busy=1 sets the pending flag. Multiple requests collapse into one.
- o_led_out = waveform XOR INVERT_OUT, registered (no combinational path from the FSM).
- Counter widths are sized from BIT_CYC and RESET_CYC with $clog2. The bit counter runs 23..0 and the pixel counter runs 0..NUM_LEDS-1 with no wrap past NUM_LEDS-1.

Decomposition:
- Shared package neopixel_pkg holds:
  - the FSM state encoding;
  - the GRB field offsets (G=23:16, R=15:8, B=7:0);
  - default timing constants for 50 MHz;
  - a helper function computing counter widths.
- One sub-module, neopixel_fbuf: an NUM_LEDS x 24 simple dual-port RAM with one write port and one synchronous read port and no reset, so it infers block or distributed RAM.
- The FSM, timing counters and output register stay in neopixel_strip_ctrl.

Test Plan:
- NUM_LEDS=2; write pixel0=24'hFF0000, pixel1=24'h00000F; pulse i_start -> decoder captures 48 bits: eight 40-cycle highs, sixteen 20-cycle highs, twenty 20-cycle highs, four 40-cycle highs. Every bit period is 63 cycles. o_frame_done pulses once, 3000 cycles after the last bit. o_busy falls on the next cycle.
- Start latency: i_start at edge k -> o_busy=1 at k+1, waveform rising edge at k+2. Across the pixel0/pixel1 boundary, consecutive rising edges are exactly 63 cycles apart.
- i_start pulsed mid-frame -> exactly one extra frame starts right after LATCH with no IDLE cycle between frames. Pulsed twice -> still only one extra frame.
- During pixel0 transmission, write pixel0=24'h000000 and pixel1=24'hAAAAAA -> the current frame sends the old pixel0 and the new pixel1; the next frame sends the new pixel0. A write to address NUM_LEDS leaves the captured data unchanged.
- Assert i_reset mid-bit -> next cycle o_led_out=INVERT_OUT and o_busy=0, with no o_frame_done. A subsequent i_start transmits the pre-reset buffer contents intact.
- AUTO_REFRESH=1, INVERT_OUT=1 -> frames repeat back-to-back with o_frame_done pulses every NUM_LEDS*24*63+3000+1 cycles. The pin idles high, and pulses are low-going.
